// File: rtl/leaf_pkg.sv
// Shared definitions for the leaf outbound path.
//   - Packet layout: {vld[48], dst_leaf[47:44], dst_port[43:40], addr[39:33], rsvd[32], payload[31:0]}
//   - dest_entry_t : one destination table entry {dst_leaf, dst_port}
//   - arb_state_t  : arbiter FSM states (IDLE, BURST)
//   - make_packet  : assembles a valid packet from its fields
package leaf_pkg;

    localparam int PACKET_BITS   = 49;
    localparam int PAYLOAD_BITS  = 32;
    localparam int DEST_BITS     = 8;
    localparam int PKT_VLD_BIT   = 48;
    localparam int PKT_LEAF_LSB  = 44;
    localparam int PKT_PORT_LSB  = 40;
    localparam int PKT_ADDR_LSB  = 33;
    localparam int PKT_ADDR_BITS = 7;
    localparam int PKT_RSVD_BIT  = 32;

    typedef struct packed {
        logic [3:0] dst_leaf;
        logic [3:0] dst_port;
    } dest_entry_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    function automatic logic [PACKET_BITS-1:0] make_packet(
        input dest_entry_t               dest,
        input logic [PKT_ADDR_BITS-1:0]  addr,
        input logic [PAYLOAD_BITS-1:0]   payload
    );
        logic [PACKET_BITS-1:0] pkt;
        pkt = '0;
        pkt[PKT_VLD_BIT]                   = 1'b1;
        pkt[PKT_LEAF_LSB +: 4]             = dest.dst_leaf;
        pkt[PKT_PORT_LSB +: 4]             = dest.dst_port;
        pkt[PKT_ADDR_LSB +: PKT_ADDR_BITS] = addr;
        pkt[PKT_RSVD_BIT]                  = 1'b0;
        pkt[PAYLOAD_BITS-1:0]              = payload;
        return pkt;
    endfunction

endpackage

// File: rtl/leaf_credit_counter.sv
// Free-space credit counter for one destination input buffer.
//   clk, reset   : clock, synchronous active-high reset (credit -> full)
//   debit        : one word sent this cycle (never asserted at zero credit)
//   credit_ret   : RETURN_SIZE words freed downstream this cycle
//   credit_zero  : no credit left; the port must not be granted
// Full credit is 2**(CNT_BITS-1); returns saturate there. Debit and return
// in the same cycle are both applied.
module leaf_credit_counter #(
    parameter int CNT_BITS    = 8,
    parameter int RETURN_SIZE = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic debit,
    input  logic credit_ret,
    output logic credit_zero
);

    // One spare bit so credit + return cannot wrap before saturation.
    localparam int SUM_BITS = CNT_BITS + 1;
    localparam logic [SUM_BITS-1:0] MAX_CREDIT = SUM_BITS'(2 ** (CNT_BITS - 1));
    localparam logic [SUM_BITS-1:0] RET_AMT    = SUM_BITS'(RETURN_SIZE);

    logic [CNT_BITS-1:0] credit_reg, credit_next;
    logic [SUM_BITS-1:0] sum;

    always_comb begin
        sum = {1'b0, credit_reg};
        if (credit_ret) begin
            sum = sum + RET_AMT;
        end
        if (debit) begin
            sum = sum - SUM_BITS'(1);
        end
        credit_next = (sum > MAX_CREDIT) ? MAX_CREDIT[CNT_BITS-1:0] : sum[CNT_BITS-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            credit_reg <= MAX_CREDIT[CNT_BITS-1:0];
        end else begin
            credit_reg <= credit_next;
        end
    end

    assign credit_zero = (credit_reg == '0);

endmodule

// File: rtl/leaf_out_arbiter.sv
// Shares one leaf's outbound link between NUM_OUT_PORTS user streams.
// Round-robin arbitration with bursts of up to MAX_BURST words, per-port
// credit tracking of destination buffer space, and a registered 49b packet
// output that honours pkt_ready backpressure.
//   din_user/vld_user/ack_user : user streams (ack is combinational, one-hot or zero)
//   cfg_we/cfg_port/cfg_dst    : destination table write {dst_leaf, dst_port}
//   credit_vld/credit_port     : credit return of FREESPACE_UPDATE_SIZE words
//   pkt_out/pkt_ready          : packet to link and link ready
// Optional build macro LEAF_ARB_STATS_EN adds stat_grants: per-port 16b
// wrapping accepted-word counters, cleared by reset.
module leaf_out_arbiter
    import leaf_pkg::*;
#(
    parameter int NUM_OUT_PORTS         = 2,
    parameter int NUM_BRAM_ADDR_BITS    = 7,
    parameter int FREESPACE_UPDATE_SIZE = 64,
    parameter int MAX_BURST             = 8
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_user,
    input  logic [NUM_OUT_PORTS-1:0]            vld_user,
    output logic [NUM_OUT_PORTS-1:0]            ack_user,
    input  logic                                cfg_we,
    input  logic [3:0]                          cfg_port,
    input  logic [DEST_BITS-1:0]                cfg_dst,
    input  logic                                credit_vld,
    input  logic [3:0]                          credit_port,
    output logic [PACKET_BITS-1:0]              pkt_out,
    input  logic                                pkt_ready
`ifdef LEAF_ARB_STATS_EN
    ,
    output logic [NUM_OUT_PORTS*16-1:0]         stat_grants
`endif
);

    localparam int PW = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_t             state_reg, state_next;
    logic [PW-1:0]          owner_reg, owner_next;
    logic [PW-1:0]          rr_reg, rr_next;
    logic [CW-1:0]          burst_cnt_reg, burst_cnt_next;
    logic [PACKET_BITS-1:0] pkt_reg, pkt_next;

    logic [PW-1:0]          owner_inc, search_base, sel, idx;
    logic [NUM_OUT_PORTS-1:0] eligible;
    logic                   cont, leaving, have_sel, slot_free, accept;
    logic [PACKET_BITS-1:0] port_pkt [NUM_OUT_PORTS];

    // Per-port state: destination entry, address counter, credits, packet.
    // Index decodes compare against each real port number, so out-of-range
    // cfg_port / credit_port values simply match nothing.
    for (genvar gi = 0; gi < NUM_OUT_PORTS; gi++) begin : g_port
        dest_entry_t              dest_reg;
        logic [PKT_ADDR_BITS-1:0] addr_reg;
        logic                     take, credit_zero;

        assign take         = accept && (sel == PW'(gi));
        assign ack_user[gi] = take;

        always_ff @(posedge clk) begin
            if (reset) begin
                dest_reg <= '0;
                addr_reg <= '0;
            end else begin
                if (cfg_we && (cfg_port == 4'(gi))) begin
                    dest_reg <= cfg_dst;
                end
                if (take) begin
                    addr_reg <= addr_reg + 1'b1;
                end
            end
        end

        leaf_credit_counter #(
            .CNT_BITS    (NUM_BRAM_ADDR_BITS + 1),
            .RETURN_SIZE (FREESPACE_UPDATE_SIZE)
        ) u_credit (
            .clk         (clk),
            .reset       (reset),
            .debit       (take),
            .credit_ret  (credit_vld && (credit_port == 4'(gi))),
            .credit_zero (credit_zero)
        );

        assign eligible[gi] = vld_user[gi] && !credit_zero;
        assign port_pkt[gi] = make_packet(dest_reg, addr_reg,
                                          din_user[gi*PAYLOAD_BITS +: PAYLOAD_BITS]);

`ifdef LEAF_ARB_STATS_EN
        logic [15:0] grants_reg;
        always_ff @(posedge clk) begin
            if (reset) begin
                grants_reg <= '0;
            end else if (take) begin
                grants_reg <= grants_reg + 16'd1;
            end
        end
        assign stat_grants[gi*16 +: 16] = grants_reg;
`endif
    end

    // A burst that has to end re-arbitrates in the same cycle from owner+1,
    // so back-to-back bursts of different ports leave no dead cycle.
    always_comb begin
        owner_inc   = (owner_reg == PW'(NUM_OUT_PORTS - 1)) ? '0 : owner_reg + 1'b1;
        cont        = (state_reg == BURST) && (burst_cnt_reg < CW'(MAX_BURST))
                      && eligible[owner_reg];
        leaving     = (state_reg == BURST) && !cont;
        search_base = leaving ? owner_inc : rr_reg;
        have_sel    = cont;
        sel         = owner_reg;
        idx         = '0;
        if (!cont) begin
            // Scan from the far end so the port nearest search_base wins.
            for (int i = NUM_OUT_PORTS - 1; i >= 0; i--) begin
                idx = PW'((int'(search_base) + i) % NUM_OUT_PORTS);
                if (eligible[idx]) begin
                    sel      = idx;
                    have_sel = 1'b1;
                end
            end
        end

        slot_free = !pkt_reg[PKT_VLD_BIT] || pkt_ready;
        accept    = have_sel && slot_free && !reset;

        state_next     = state_reg;
        owner_next     = owner_reg;
        burst_cnt_next = burst_cnt_reg;
        rr_next        = leaving ? owner_inc : rr_reg;
        pkt_next       = pkt_reg;

        if (accept) begin
            state_next     = BURST;
            owner_next     = sel;
            burst_cnt_next = cont ? burst_cnt_reg + 1'b1 : CW'(1);
            pkt_next       = port_pkt[sel];
        end else begin
            if (!cont) begin
                state_next     = IDLE;
                burst_cnt_next = '0;
            end
            if (pkt_ready) begin
                pkt_next = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            owner_reg     <= '0;
            rr_reg        <= '0;
            burst_cnt_reg <= '0;
            pkt_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            rr_reg        <= rr_next;
            burst_cnt_reg <= burst_cnt_next;
            pkt_reg       <= pkt_next;
        end
    end

    assign pkt_out = pkt_reg;

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Directed bench for leaf_out_arbiter: alternating bursts, credit exhaustion
// and return, backpressure stall, destination config with address wrap,
// credit saturation, and reset during a burst.
module tb_leaf_out_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] din_user;
    logic [1:0]  vld_user;
    logic [1:0]  ack_user;
    logic        cfg_we;
    logic [3:0]  cfg_port;
    logic [7:0]  cfg_dst;
    logic        credit_vld;
    logic [3:0]  credit_port;
    logic [48:0] pkt_out;
    logic        pkt_ready;
`ifdef LEAF_ARB_STATS_EN
    logic [31:0] stat_grants;
`endif

    always #5 clk = ~clk;

    leaf_out_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .din_user    (din_user),
        .vld_user    (vld_user),
        .ack_user    (ack_user),
        .cfg_we      (cfg_we),
        .cfg_port    (cfg_port),
        .cfg_dst     (cfg_dst),
        .credit_vld  (credit_vld),
        .credit_port (credit_port),
        .pkt_out     (pkt_out),
        .pkt_ready   (pkt_ready)
`ifdef LEAF_ARB_STATS_EN
        ,
        .stat_grants (stat_grants)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    logic [15:0] seq0, seq1;
    int          acc0, acc1;
    logic [1:0]  ack_s;
    logic [48:0] pkt_s;

    function automatic logic [48:0] pk(input logic [7:0] d, input logic [6:0] a,
                                       input logic [31:0] pl);
        return {1'b1, d, a, 1'b0, pl};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1: drive payloads, sample at the falling edge,
    // then advance past the next rising edge and record accepted words.
    task automatic step();
        din_user = {16'd1, seq1, 16'd0, seq0};
        #4;
        ack_s = ack_user;
        pkt_s = pkt_out;
        @(posedge clk);
        #1;
        if (ack_s[0]) begin seq0++; acc0++; end
        if (ack_s[1]) begin seq1++; acc1++; end
    endtask

    task automatic do_reset();
        reset = 1'b1; vld_user = 2'b00; credit_vld = 1'b0; cfg_we = 1'b0; pkt_ready = 1'b1;
        step();
        step();
        reset = 1'b0;
        seq0 = '0; seq1 = '0; acc0 = 0; acc1 = 0;
    endtask

    initial begin
        int base;
        int n;
        reset = 1'b1; din_user = '0; vld_user = 2'b00; cfg_we = 1'b0; cfg_port = '0;
        cfg_dst = '0; credit_vld = 1'b0; credit_port = '0; pkt_ready = 1'b1;
        seq0 = '0; seq1 = '0; acc0 = 0; acc1 = 0;
        @(posedge clk);
        #1;

        // Reset state: requests present but nothing granted or sent.
        vld_user = 2'b11;
        step(); check("reset_ack", 64'(ack_s), 64'd0);
        step(); check("reset_pkt", 64'(pkt_s), 64'd0);
        reset = 1'b0;
        seq0 = '0; seq1 = '0; acc0 = 0; acc1 = 0;

        // Both ports always valid: 8 words p0, 8 words p1, no gaps.
        for (int c = 0; c < 32; c++) begin
            step();
            check($sformatf("alt_ack_c%0d", c), 64'(ack_s), ((c / 8) % 2 == 0) ? 64'd1 : 64'd2);
            if (c == 1)  check("alt_pkt_p0w0", 64'(pkt_s), 64'(pk(8'h00, 7'd0, {16'd0, 16'd0})));
            if (c == 9)  check("alt_pkt_p1w0", 64'(pkt_s), 64'(pk(8'h00, 7'd0, {16'd1, 16'd0})));
            if (c == 17) check("alt_pkt_p0w8", 64'(pkt_s), 64'(pk(8'h00, 7'd8, {16'd0, 16'd8})));
        end
        $display("alternation: %0d p0 words, %0d p1 words", acc0, acc1);

        // Backpressure mid-burst.
        do_reset();
        vld_user = 2'b01;
        step(); step(); step();
        pkt_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            check($sformatf("stall_ack_c%0d", c), 64'(ack_s), 64'd0);
            check($sformatf("stall_pkt_c%0d", c), 64'(pkt_s), 64'(pk(8'h00, 7'd2, {16'd0, 16'd2})));
        end
        pkt_ready = 1'b1;
        step();
        check("stall_release_ack", 64'(ack_s), 64'd1);
        check("stall_release_pkt", 64'(pkt_s), 64'(pk(8'h00, 7'd2, {16'd0, 16'd2})));
        step();
        check("stall_next_pkt", 64'(pkt_s), 64'(pk(8'h00, 7'd3, {16'd0, 16'd3})));
        $display("backpressure: %0d words accepted", acc0);

        // Port0 alone: credit runs out after 128 words.
        do_reset();
        vld_user = 2'b01;
        for (int c = 0; c < 140; c++) step();
        check("credit_exhaust_count", 64'(acc0), 64'd128);
        check("credit_exhaust_ack", 64'(ack_s), 64'd0);
        check("credit_exhaust_pkt_idle", 64'(pkt_s[48]), 64'd0);
        credit_vld = 1'b1; credit_port = 4'd2;
        step();
        credit_vld = 1'b0;
        step(); step();
        check("credit_bad_port_ignored", 64'(acc0), 64'd128);
        credit_vld = 1'b1; credit_port = 4'd0;
        step();
        credit_vld = 1'b0;
        base = acc0;
        for (int c = 0; c < 80; c++) step();
        check("credit_return_words", 64'(acc0 - base), 64'd64);
        $display("credit return: %0d words total", acc0);

        // Return at credit 100 saturates at 128.
        do_reset();
        vld_user = 2'b01;
        for (int c = 0; c < 28; c++) step();
        vld_user = 2'b00; credit_vld = 1'b1; credit_port = 4'd0;
        step();
        credit_vld = 1'b0; vld_user = 2'b01;
        base = acc0;
        for (int c = 0; c < 140; c++) step();
        check("credit_saturate", 64'(acc0 - base), 64'd128);

        // Accept and return in the same cycle at credit 10 -> 73.
        do_reset();
        vld_user = 2'b01;
        for (int c = 0; c < 118; c++) step();
        credit_vld = 1'b1; credit_port = 4'd0;
        step();
        credit_vld = 1'b0;
        check("credit_simul_ack", 64'(ack_s), 64'd1);
        base = acc0;
        for (int c = 0; c < 100; c++) step();
        check("credit_simul_words", 64'(acc0 - base), 64'd73);
        $display("credit saturation/simultaneous: done");

        // Port1 destination 0x3A, 130 words with address wrap.
        do_reset();
        cfg_we = 1'b1; cfg_port = 4'd1; cfg_dst = 8'h3A;
        step();
        cfg_port = 4'd3; cfg_dst = 8'hFF;
        step();
        cfg_we = 1'b0;
        n = 0;
        for (int c = 0; c < 300; c++) begin
            vld_user    = {(acc1 < 130), 1'b0};
            credit_vld  = (c == 80);
            credit_port = 4'd1;
            step();
            if (pkt_s[48]) begin
                check($sformatf("cfg_dst_w%0d", n), 64'(pkt_s[47:40]), 64'h3A);
                check($sformatf("cfg_addr_w%0d", n), 64'(pkt_s[39:33]), 64'(n % 128));
                check($sformatf("cfg_payload_w%0d", n), 64'(pkt_s[31:0]), 64'({16'd1, 16'(n)}));
                n++;
            end
        end
        credit_vld = 1'b0;
        check("cfg_word_count", 64'(n), 64'd130);
        $display("dest config: %0d packets", n);

        // Reset in the middle of a p1 burst.
        do_reset();
        vld_user = 2'b11;
        for (int c = 0; c < 11; c++) step();
        reset = 1'b1;
        step();
        check("midreset_ack", 64'(ack_s), 64'd0);
        step();
        check("midreset_ack2", 64'(ack_s), 64'd0);
        check("midreset_pkt", 64'(pkt_s), 64'd0);
        reset = 1'b0;
        seq0 = '0; seq1 = '0; acc0 = 0; acc1 = 0;
        step();
        check("midreset_rr_first", 64'(ack_s), 64'd1);
        step();
        check("midreset_first_pkt", 64'(pkt_s), 64'(pk(8'h00, 7'd0, {16'd0, 16'd0})));
        $display("mid-burst reset: done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
